mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- System-bus memory responder: the target end of the bus transaction driven by the CPU datapath.
- The datapath drives address (dad_), write data (ddt_) and segment number (nb). It receives read data (rdt_) and handshake replies.
- The block decodes the segment and address window, holds a local word array, and answers read and write requests with a fixed-latency ok_ reply.
- It holds ok_ until the requester releases the request.
- Sits on the bus beside the real memory controller. Used as on-chip memory and as the bench target for CPU bus cycles.

Parameters:
AW, 12, storage address width in words; array holds 2**AW 16-bit words (AW 1..15)
BASE_HI, 0, value the address bits dad[0:15-AW] must equal for a hit
SEG, 0, 4-bit segment number the nb input must equal for a hit
LATENCY, 2, cycles from request acceptance to ok_ assertion (1..15)

Ports:
clk_sys  in  1  system clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
nb  in  4  segment number, active-high, bit 0 MSB
dad_  in  16  address, active-low, bit 0 MSB
ddt_  in  16  write data, active-low
rd_  in  1  read request, active-low, level
wr_  in  1  write request, active-low, level
rdt_  out  16  read data, active-low; 16'hffff when not driving
ok_  out  1  transfer-complete reply, active-low
en_  out  1  protocol-error reply, active-low
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Internally invert dad_, ddt_, rd_ and wr_. Storage is active-high words; bit 0 is the MSB throughout.
- Reset (any state, including mid-transaction):
  - State goes to IDLE.
  - Outputs: ok_=1, en_=1, rdt_=16'hffff, busy=0.
  - Latency counter cleared.
  - Array contents are not cleared; a write whose ok_ has not yet been issued is not performed.
- Hit: nb==SEG and dad[0:15-AW]==BASE_HI. Word index is dad[16-AW:15].
- States: IDLE, WAIT, ACK, ERR, REL.
- IDLE, rd and wr both asserted -> ERR, regardless of hit. Next cycle en_=0, held while either request is asserted.
- IDLE, exactly one request asserted and hit:
  - Latch kind, index and write data.
  - Load counter with LATENCY-1 and go to WAIT.
  - Later bus changes are ignored.
- IDLE, exactly one request asserted and miss: stay in IDLE and give no reply. The initiator handles its own timeout.
- WAIT:
  - Request still asserted: counter decrements each cycle. On the cycle it is 0, go to ACK.
  - Request withdrawn (both high): abort to IDLE with no reply and no write.
  - LATENCY=1: WAIT lasts one cycle, so ok_ goes low 2 edges after acceptance; general latency is LATENCY+1 edges from the edge that samples the request.
- Entering ACK:
  - Write: array[index] <= latched data on the same edge.
  - Read: the read-data register captures array[index].
- ACK:
  - ok_=0.
  - rdt_ = ~read register for reads, 16'hffff for writes.
  - Held until the latched request line goes high, then go to REL.
  - The other request line is ignored while in ACK.
- ERR: en_=0. Go to REL when both requests are high.
- REL: all replies released; unconditionally go to IDLE next cycle.
  - REL gives a one-cycle minimum gap, so a request held low through ACK is never re-accepted.
  - Earliest new acceptance is the edge after REL.
- Outputs ok_, en_ and rdt_ are registered; no combinational path from bus inputs to outputs.

Test Plan:
- Write then read:
  - Stimulus: LATENCY=2, nb=0, dad_=~16'h0123, ddt_=~16'hbeef, wr_=0.
  - Expect ok_=0 on the 3rd edge after the sampling edge; release wr_ -> ok_=1 next edge, REL, IDLE.
  - Then rd_=0 at the same address -> ok_=0 with rdt_=~16'hbeef until rd_ is released, then rdt_=16'hffff.
- Miss:
  - Stimulus: nb=4'h1, or dad_=~16'h1000 (upper bits nonzero with AW=12), rd_ held 50 cycles.
  - Expect ok_, en_ and rdt_ stay idle and busy=0 throughout.
- Protocol error:
  - Stimulus: rd_=0 and wr_=0 together.
  - Expect en_=0 next edge, ok_=1, array unchanged; release both -> en_=1 after REL.
- Abort:
  - Stimulus: wr_=0 to word 5 with data 16'h1111, LATENCY=4; raise wr_ after 2 cycles.
  - Expect no ok_; a later read of word 5 returns its previous value.
- Reset mid-ACK:
  - Stimulus: assert rst while ok_=0 on a read.
  - Expect ok_=1, rdt_=16'hffff, busy=0 on the next edge; previously written data still readable after reset.
- Held request:
  - Stimulus: keep rd_=0 through ACK, raise it for 1 cycle, lower again.
  - Expect exactly one ok_ pulse per low period, with the second acceptance no earlier than the edge after REL.

Source files
------------

// File: rtl/mem_responder.sv
// System-bus memory responder: decodes segment/address window, holds a local
// word array and answers single read/write requests with a fixed-latency ok_.
module mem_responder #(
    parameter int unsigned AW      = 12,
    parameter int unsigned BASE_HI = 0,
    parameter int unsigned SEG     = 0,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [3:0]  nb,
    input  logic [15:0] dad_,
    input  logic [15:0] ddt_,
    input  logic        rd_,
    input  logic        wr_,
    output logic [15:0] rdt_,
    output logic        ok_,
    output logic        en_,
    output logic        busy
);

    localparam int unsigned HW = 16 - AW;
    localparam logic [HW-1:0] BASE_V = HW'(BASE_HI);
    localparam logic [3:0]    SEG_V  = 4'(SEG);
    localparam logic [3:0]    LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_ERR,
        S_REL
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          kind_q, kind_d;      // 1 = write
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ok_q, ok_d;
    logic          en_q, en_d;
    logic [15:0]   rdt_q, rdt_d;
    logic          mem_we;
    logic [15:0]   mem_q [0:(1 << AW) - 1];

    logic [15:0] dad;
    logic [15:0] ddt;
    logic        rd;
    logic        wr;
    logic        hit;

    // Bus bit 0 is the MSB, so dad[0:15-AW] is the top HW bits of the vector.
    always_comb begin
        dad = ~dad_;
        ddt = ~ddt_;
        rd  = ~rd_;
        wr  = ~wr_;
        hit = (nb == SEG_V) && (dad[15 -: HW] == BASE_V);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ok_d    = 1'b1;
        en_d    = 1'b1;
        rdt_d   = '1;
        mem_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd && wr) begin
                    state_d = S_ERR;
                    en_d    = 1'b0;
                end else if ((rd ^ wr) && hit) begin
                    state_d = S_WAIT;
                    kind_d  = wr;
                    idx_d   = dad[AW-1:0];
                    wdata_d = ddt;
                    cnt_d   = LAT_M1;
                end
            end
            S_WAIT: begin
                if (!rd && !wr) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_ACK;
                    if (kind_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // ok_ asserts from the second ACK cycle, giving LATENCY+1 edges overall.
            S_ACK: begin
                if (kind_q ? wr : rd) begin
                    ok_d  = 1'b0;
                    rdt_d = kind_q ? '1 : ~rdata_q;
                end else begin
                    state_d = S_REL;
                end
            end
            S_ERR: begin
                if (!rd && !wr) begin
                    state_d = S_REL;
                end else begin
                    en_d = 1'b0;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b1;
            en_q    <= 1'b1;
            rdt_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ok_q    <= ok_d;
            en_q    <= en_d;
            rdt_q   <= rdt_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign rdt_ = rdt_q;
    assign ok_  = ok_q;
    assign en_  = en_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: instance A uses LATENCY=2,
// instance B uses LATENCY=4 for the abort scenario.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  a_nb = 4'h0;
    logic [15:0] a_dad_ = '1;
    logic [15:0] a_ddt_ = '1;
    logic        a_rd_ = 1'b1;
    logic        a_wr_ = 1'b1;
    logic [15:0] a_rdt_;
    logic        a_ok_;
    logic        a_en_;
    logic        a_busy;

    logic [3:0]  b_nb = 4'h0;
    logic [15:0] b_dad_ = '1;
    logic [15:0] b_ddt_ = '1;
    logic        b_rd_ = 1'b1;
    logic        b_wr_ = 1'b1;
    logic [15:0] b_rdt_;
    logic        b_ok_;
    logic        b_en_;
    logic        b_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_responder u_a (
        .clk_sys (clk),
        .rst     (rst),
        .nb      (a_nb),
        .dad_    (a_dad_),
        .ddt_    (a_ddt_),
        .rd_     (a_rd_),
        .wr_     (a_wr_),
        .rdt_    (a_rdt_),
        .ok_     (a_ok_),
        .en_     (a_en_),
        .busy    (a_busy)
    );

    mem_responder #(.LATENCY(4)) u_b (
        .clk_sys (clk),
        .rst     (rst),
        .nb      (b_nb),
        .dad_    (b_dad_),
        .ddt_    (b_ddt_),
        .rd_     (b_rd_),
        .wr_     (b_wr_),
        .rdt_    (b_rdt_),
        .ok_     (b_ok_),
        .en_     (b_en_),
        .busy    (b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request transfer on A; edges counts from (and including) the sampling edge.
    task automatic xfer_a(input logic is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output int edges);
        a_dad_ = ~addr;
        a_ddt_ = ~wdata;
        if (is_wr) a_wr_ = 1'b0; else a_rd_ = 1'b0;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            edges++;
            if (a_ok_ === 1'b0) break;
        end
        rdata = ~a_rdt_;
        a_rd_ = 1'b1;
        a_wr_ = 1'b1;
        step();
        step();
    endtask

    task automatic xfer_b(input logic is_wr, input logic [15:0] addr, input logic [15:0] wdata,
                          output logic [15:0] rdata, output int edges);
        b_dad_ = ~addr;
        b_ddt_ = ~wdata;
        if (is_wr) b_wr_ = 1'b0; else b_rd_ = 1'b0;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            edges++;
            if (b_ok_ === 1'b0) break;
        end
        rdata = ~b_rdt_;
        b_rd_ = 1'b1;
        b_wr_ = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if (a_ok_ !== 1'b1) begin errors++; $display("FAIL reset_ok got %b want 1", a_ok_); end
        checks++; if (a_en_ !== 1'b1) begin errors++; $display("FAIL reset_en got %b want 1", a_en_); end
        checks++; if (a_rdt_ !== 16'hffff) begin errors++; $display("FAIL reset_rdt got %h want ffff", a_rdt_); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
    endtask

    task automatic test_write_read();
        int n;
        a_nb   = 4'h0;
        a_dad_ = ~16'h0123;
        a_ddt_ = ~16'hbeef;
        a_wr_  = 1'b0;
        step();  // sampling edge
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wr_accept_busy got %b want 1", a_busy); end
        step();
        step();
        checks++; if (a_ok_ !== 1'b1) begin errors++; $display("FAIL wr_ok_early got %b want 1", a_ok_); end
        step();  // third edge after sampling
        checks++; if (a_ok_ !== 1'b0) begin errors++; $display("FAIL wr_ok_latency got %b want 0", a_ok_); end
        checks++; if (a_rdt_ !== 16'hffff) begin errors++; $display("FAIL wr_rdt got %h want ffff", a_rdt_); end
        step();
        checks++; if (a_ok_ !== 1'b0) begin errors++; $display("FAIL wr_ok_hold got %b want 0", a_ok_); end
        a_wr_ = 1'b1;
        step();
        checks++; if (a_ok_ !== 1'b1) begin errors++; $display("FAIL wr_ok_release got %b want 1", a_ok_); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL wr_rel_busy got %b want 1", a_busy); end
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got %b want 0", a_busy); end

        a_rd_ = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (a_ok_ === 1'b0) break;
        end
        checks++; if (n !== 4 || a_ok_ !== 1'b0) begin errors++; $display("FAIL rd_latency got %0d edges ok_=%b want 4 edges ok_=0", n, a_ok_); end
        checks++; if (a_rdt_ !== 16'h4110) begin errors++; $display("FAIL rd_data got %h want 4110", a_rdt_); end
        step();
        step();
        checks++; if (a_ok_ !== 1'b0 || a_rdt_ !== 16'h4110) begin errors++; $display("FAIL rd_hold got ok_=%b rdt_=%h want ok_=0 rdt_=4110", a_ok_, a_rdt_); end
        a_rd_ = 1'b1;
        step();
        checks++; if (a_ok_ !== 1'b1 || a_rdt_ !== 16'hffff) begin errors++; $display("FAIL rd_release got ok_=%b rdt_=%h want ok_=1 rdt_=ffff", a_ok_, a_rdt_); end
        step();
    endtask

    task automatic test_miss();
        int bad;
        for (int pass = 0; pass < 2; pass++) begin
            a_nb   = (pass == 0) ? 4'h1 : 4'h0;
            a_dad_ = (pass == 0) ? ~16'h0123 : ~16'h1000;
            a_rd_  = 1'b0;
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                step();
                if (a_ok_ !== 1'b1 || a_en_ !== 1'b1 || a_rdt_ !== 16'hffff || a_busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL miss_%0d got %0d active cycles want 0 (ok_=%b en_=%b rdt_=%h busy=%b)",
                         pass, bad, a_ok_, a_en_, a_rdt_, a_busy);
            end
            a_rd_ = 1'b1;
            a_nb  = 4'h0;
            step();
        end
    endtask

    task automatic test_proto_error();
        logic [15:0] d;
        int n;
        a_dad_ = ~16'h0123;
        a_ddt_ = ~16'h1234;
        a_rd_  = 1'b0;
        a_wr_  = 1'b0;
        step();
        checks++; if (a_en_ !== 1'b0 || a_ok_ !== 1'b1) begin errors++; $display("FAIL err_assert got en_=%b ok_=%b want en_=0 ok_=1", a_en_, a_ok_); end
        step();
        step();
        checks++; if (a_en_ !== 1'b0) begin errors++; $display("FAIL err_hold got %b want 0", a_en_); end
        a_rd_ = 1'b1;
        a_wr_ = 1'b1;
        step();
        checks++; if (a_en_ !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL err_release got en_=%b busy=%b want en_=1 busy=1", a_en_, a_busy); end
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL err_idle got busy=%b want 0", a_busy); end
        xfer_a(1'b0, 16'h0123, 16'h0000, d, n);
        checks++; if (d !== 16'hbeef) begin errors++; $display("FAIL err_array got %h want beef", d); end
    endtask

    task automatic test_abort();
        logic [15:0] d;
        int n;
        int lows;
        xfer_b(1'b1, 16'h0005, 16'h2222, d, n);
        checks++; if (n !== 6) begin errors++; $display("FAIL b_wr_latency got %0d edges want 6", n); end
        b_dad_ = ~16'h0005;
        b_ddt_ = ~16'h1111;
        b_wr_  = 1'b0;
        step();  // sampling edge
        step();
        step();
        b_wr_ = 1'b1;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (b_ok_ !== 1'b1) lows++;
        end
        checks++; if (lows != 0 || b_busy !== 1'b0) begin errors++; $display("FAIL abort_reply got %0d ok_ cycles busy=%b want 0 busy=0", lows, b_busy); end
        xfer_b(1'b0, 16'h0005, 16'h0000, d, n);
        checks++; if (d !== 16'h2222 || n !== 6) begin errors++; $display("FAIL abort_data got %h in %0d edges want 2222 in 6", d, n); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        int n;
        a_dad_ = ~16'h0123;
        a_rd_  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_ok_ === 1'b0) break;
        end
        checks++; if (a_ok_ !== 1'b0) begin errors++; $display("FAIL rst_mid_setup got ok_=%b want 0", a_ok_); end
        rst = 1'b1;
        step();
        checks++; if (a_ok_ !== 1'b1 || a_rdt_ !== 16'hffff || a_busy !== 1'b0 || a_en_ !== 1'b1)
            begin errors++; $display("FAIL rst_mid got ok_=%b rdt_=%h busy=%b en_=%b want 1 ffff 0 1", a_ok_, a_rdt_, a_busy, a_en_); end
        rst = 1'b0;
        a_rd_ = 1'b1;
        step();
        xfer_a(1'b0, 16'h0123, 16'h0000, d, n);
        checks++; if (d !== 16'hbeef) begin errors++; $display("FAIL rst_keep got %h want beef", d); end

        // A write interrupted by reset before ok_ must not land.
        xfer_a(1'b1, 16'h0124, 16'h7777, d, n);
        a_dad_ = ~16'h0124;
        a_ddt_ = ~16'h5555;
        a_wr_  = 1'b0;
        step();
        step();
        rst = 1'b1;
        a_wr_ = 1'b1;
        step();
        rst = 1'b0;
        step();
        xfer_a(1'b0, 16'h0124, 16'h0000, d, n);
        checks++; if (d !== 16'h7777) begin errors++; $display("FAIL rst_write got %h want 7777", d); end
    endtask

    task automatic test_held();
        int n;
        int pulses;
        logic prev;
        a_dad_ = ~16'h0123;
        a_rd_  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (a_ok_ === 1'b0) break;
        end
        prev = a_ok_;
        pulses = (a_ok_ === 1'b0) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (prev === 1'b1 && a_ok_ === 1'b0) pulses++;
            prev = a_ok_;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
        a_rd_ = 1'b1;
        step();  // release sampled, state REL
        checks++; if (a_ok_ !== 1'b1) begin errors++; $display("FAIL held_release got %b want 1", a_ok_); end
        a_rd_ = 1'b0;
        step();  // REL ignores the request
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL held_rel_gap got busy=%b want 0", a_busy); end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (a_ok_ === 1'b0) break;
        end
        checks++; if (n !== 5 || a_ok_ !== 1'b0) begin errors++; $display("FAIL held_reaccept got %0d edges ok_=%b want 5 edges ok_=0", n, a_ok_); end
        a_rd_ = 1'b1;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_miss();
        test_proto_error();
        test_abort();
        test_reset_mid();
        test_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
